// File: rtl/ping_pong_scheduler_pkg.sv
// Shared types and default sizes for the ping-pong scheduler slice.
// The flip feature is enabled with the PPS_FLIP_EN macro.
package ppc_pkg;

  localparam int PPC_WIDTH = 4;
  localparam int PPC_BW    = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FINISH
  } state_e;

endpackage

// File: rtl/ping_pong_scheduler_if.sv
// Request/counter bundle between requesters and the scheduler.
// Adds flip_req/flip when PPS_FLIP_EN is defined.
interface ping_pong_scheduler_if
  import ppc_pkg::*;
#(
  parameter int WIDTH = PPC_WIDTH,
  parameter int BW    = PPC_BW
);

  logic [1:0]       req;
  logic [WIDTH-1:0] min0;
  logic [WIDTH-1:0] max0;
  logic [WIDTH-1:0] min1;
  logic [WIDTH-1:0] max1;
  logic [BW-1:0]    bnc0;
  logic [BW-1:0]    bnc1;
  logic             direction;
  logic             ctr_rst_n;
  logic             enable;
  logic [WIDTH-1:0] min;
  logic [WIDTH-1:0] max;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [1:0]       err;
`ifdef PPS_FLIP_EN
  logic [1:0]       flip_req;
  logic             flip;
`endif

`ifdef PPS_FLIP_EN
  modport master (
    output req, min0, max0, min1, max1, bnc0, bnc1, direction, flip_req,
    input  ctr_rst_n, enable, min, max, gnt, done, err, flip
  );
  modport slave (
    input  req, min0, max0, min1, max1, bnc0, bnc1, direction, flip_req,
    output ctr_rst_n, enable, min, max, gnt, done, err, flip
  );
`else
  modport master (
    output req, min0, max0, min1, max1, bnc0, bnc1, direction,
    input  ctr_rst_n, enable, min, max, gnt, done, err
  );
  modport slave (
    input  req, min0, max0, min1, max1, bnc0, bnc1, direction,
    output ctr_rst_n, enable, min, max, gnt, done, err
  );
`endif

endinterface

// File: rtl/ping_pong_scheduler_arb.sv
// Two-way round-robin arbiter; the pointer moves away from whoever was
// last granted so a tie goes to the other requester next time.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);

  // ptr_q set means requester 1 wins a tie
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    ptr_d = ptr_q;
    if (accept_i && (gnt_o != 2'b00)) begin
      ptr_d = gnt_o[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ping_pong_scheduler.sv
// Grants a bouncing up/down counter to one of two requesters and finishes
// after the requested number of turn-arounds. PPS_FLIP_EN adds flip requests.
module ping_pong_scheduler
  import ppc_pkg::*;
#(
  parameter int WIDTH = PPC_WIDTH,
  parameter int BW    = PPC_BW
) (
  input logic                  clk,
  input logic                  rst_n,
  ping_pong_scheduler_if.slave bus
);

  state_e           state_q;
  logic [1:0]       gnt_q;
  logic             enable_q;
  logic             ctrRstN_q;
  logic [1:0]       done_q;
  logic [1:0]       err_q;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
  logic [BW:0]      bounceCnt_q;
  logic [BW:0]      bounceCnt_d;
  logic             dir_q;

  logic [1:0]       arbGnt;
  logic             ownerReq;
  logic [BW-1:0]    bncSel;
  logic [BW:0]      bncTarget;
  logic             turn;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (bus.req),
    .accept_i (state_q == IDLE),
    .gnt_o    (arbGnt)
  );

  assign ownerReq    = |(bus.req & gnt_q);
  assign bncSel      = gnt_q[1] ? bus.bnc1 : bus.bnc0;
  assign bncTarget   = (bncSel == '0) ? (BW+1)'(1) : {1'b0, bncSel};
  assign bounceCnt_d = bounceCnt_q + {{BW{1'b0}}, turn};

`ifdef PPS_FLIP_EN
  logic [1:0] flipReq_q;
  logic       flip_q;
  logic       flipRise;

  // a rising flip request from the owner is an extra forced turn-around
  assign flipRise = (state_q == RUN) && |(bus.flip_req & ~flipReq_q & gnt_q);
  assign turn     = (bus.direction != dir_q) || flipRise;
  assign bus.flip = flip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flipReq_q <= 2'b00;
      flip_q    <= 1'b0;
    end else begin
      flipReq_q <= bus.flip_req;
      flip_q    <= flipRise;
    end
  end
`else
  assign turn = (bus.direction != dir_q);
`endif

  // Drop of the owner's request is checked first so an abort never pulses done/err
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 2'b00;
      enable_q    <= 1'b0;
      ctrRstN_q   <= 1'b0;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      min_q       <= '0;
      max_q       <= '0;
      bounceCnt_q <= '0;
      dir_q       <= 1'b0;
    end else begin
      done_q <= 2'b00;
      err_q  <= 2'b00;
      dir_q  <= bus.direction;
      case (state_q)
        IDLE: begin
          enable_q  <= 1'b0;
          ctrRstN_q <= 1'b1;
          gnt_q     <= 2'b00;
          if (|bus.req) begin
            state_q     <= LOAD;
            gnt_q       <= arbGnt;
            ctrRstN_q   <= 1'b0;
            bounceCnt_q <= '0;
            min_q       <= arbGnt[1] ? bus.min1 : bus.min0;
            max_q       <= arbGnt[1] ? bus.max1 : bus.max0;
          end
        end
        LOAD: begin
          bounceCnt_q <= '0;
          ctrRstN_q   <= 1'b1;
          if (!ownerReq) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
          end else if (min_q >= max_q) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            err_q   <= gnt_q;
          end else begin
            state_q  <= RUN;
            enable_q <= 1'b1;
          end
        end
        RUN: begin
          if (!ownerReq) begin
            state_q  <= IDLE;
            gnt_q    <= 2'b00;
            enable_q <= 1'b0;
          end else begin
            bounceCnt_q <= bounceCnt_d;
            if (bounceCnt_d >= bncTarget) begin
              state_q  <= FINISH;
              enable_q <= 1'b0;
              done_q   <= gnt_q;
            end
          end
        end
        FINISH: begin
          state_q  <= IDLE;
          gnt_q    <= 2'b00;
          enable_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.enable    = enable_q;
  assign bus.ctr_rst_n = ctrRstN_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.min       = min_q;
  assign bus.max       = max_q;

endmodule

// File: tb/tb_ping_pong_scheduler.sv
// Self-checking bench for ping_pong_scheduler: vector table, corner-case
// sequences, then random traffic against a transaction-level model.
module tb_ping_pong_scheduler;
  import ppc_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ping_pong_scheduler_if #(.WIDTH(PPC_WIDTH), .BW(PPC_BW)) bus ();

  ping_pong_scheduler #(.WIDTH(PPC_WIDTH), .BW(PPC_BW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] req;
    logic       dir;
    logic [1:0] gnt;
    logic       en;
    logic       crn;
    logic [1:0] done;
    logic [1:0] err;
    int         mn;
    int         mx;
  } vec_t;

  vec_t vecs[9];

  // transaction-level reference: busy flag, owner, cycles since grant
  bit mBusy, mFinish;
  int mOwner, mPref, mAge, mBnc, mMin, mMax;
  bit mPrevDir;
  logic [1:0] eGnt, eDone, eErr;
  logic eEn, eCrn;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(string name, logic [1:0] g, logic en, logic crn,
                             logic [1:0] d, logic [1:0] e);
    checkVal(name, int'({bus.gnt, bus.enable, bus.ctr_rst_n, bus.done, bus.err}),
             int'({g, en, crn, d, e}));
  endtask

  task automatic applyStimulus(logic [1:0] r, logic d);
    bus.req       = r;
    bus.direction = d;
  endtask

  task automatic setBounds(int mn0, int mx0, int b0, int mn1, int mx1, int b1);
    bus.min0 = mn0[PPC_WIDTH-1:0];
    bus.max0 = mx0[PPC_WIDTH-1:0];
    bus.bnc0 = b0[PPC_BW-1:0];
    bus.min1 = mn1[PPC_WIDTH-1:0];
    bus.max1 = mx1[PPC_WIDTH-1:0];
    bus.bnc1 = b1[PPC_BW-1:0];
  endtask

  task automatic doReset(logic [1:0] reqAtRelease);
    rst_n = 1'b0;
    applyStimulus(2'b00, 1'b0);
    repeat (2) @(posedge clk);
    bus.req = reqAtRelease;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic modelReset();
    mBusy = 0; mFinish = 0; mOwner = 0; mPref = 0; mAge = 0; mBnc = 0;
    mMin = 0; mMax = 0; mPrevDir = 0;
  endtask

  task automatic modelStep();
    int target;
    eDone = 2'b00;
    eErr  = 2'b00;
    if (!mBusy) begin
      if (bus.req != 2'b00) begin
        mOwner  = (bus.req == 2'b11) ? mPref : (bus.req[0] ? 0 : 1);
        mPref   = 1 - mOwner;
        mBusy   = 1; mAge = 0; mFinish = 0; mBnc = 0;
        mMin    = (mOwner == 1) ? int'(bus.min1) : int'(bus.min0);
        mMax    = (mOwner == 1) ? int'(bus.max1) : int'(bus.max0);
      end
    end else if (mFinish) begin
      mBusy = 0;
    end else if (!bus.req[mOwner]) begin
      mBusy = 0;
    end else if (mAge == 0) begin
      if (mMin >= mMax) begin
        mBusy = 0;
        eErr[mOwner] = 1'b1;
      end else begin
        mAge = 1;
      end
    end else begin
      if (bus.direction != mPrevDir) mBnc++;
      target = (mOwner == 1) ? int'(bus.bnc1) : int'(bus.bnc0);
      if (target == 0) target = 1;
      if (mBnc >= target) begin
        mFinish = 1;
        eDone[mOwner] = 1'b1;
      end
    end
    mPrevDir = bus.direction;
    eGnt = mBusy ? ((mOwner == 1) ? 2'b10 : 2'b01) : 2'b00;
    eEn  = mBusy && (mAge > 0) && !mFinish;
    eCrn = !(mBusy && (mAge == 0));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(2'b00, 1'b0);
    setBounds(0, 4, 2, 9, 9, 1);
`ifdef PPS_FLIP_EN
    bus.flip_req = 2'b00;
`endif
    #2;
    checkOutput("resetOutputs", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    checkVal("resetMin", int'(bus.min), 0);
    checkVal("resetMax", int'(bus.max), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("crnBeforeEdge", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    checkOutput("crnAfterEdge", 2'b00, 1'b0, 1'b1, 2'b00, 2'b00);

    // lone requester 0 with two bounces, then requester 1 with empty range
    vecs[0] = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 0, 4};
    vecs[1] = '{2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 0, 4};
    vecs[2] = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 0, 4};
    vecs[3] = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 2'b00, 0, 4};
    vecs[4] = '{2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 2'b01, 2'b00, 0, 4};
    vecs[5] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 0, 0};
    vecs[6] = '{2'b10, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 9, 9};
    vecs[7] = '{2'b10, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b10, 0, 0};
    vecs[8] = '{2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 0, 0};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].req, vecs[i].dir);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].en, vecs[i].crn,
                  vecs[i].done, vecs[i].err);
      if (vecs[i].gnt != 2'b00) begin
        checkVal($sformatf("vec%0dMin", i), int'(bus.min), vecs[i].mn);
        checkVal($sformatf("vec%0dMax", i), int'(bus.max), vecs[i].mx);
      end
    end

    // simultaneous requests straight out of reset alternate owners
    setBounds(0, 4, 1, 1, 5, 1);
    doReset(2'b11);
    tick();
    checkOutput("tieLoad0", 2'b01, 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    checkOutput("tieRun0", 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
    bus.direction = 1'b1;
    tick();
    checkOutput("tieDone0", 2'b01, 1'b0, 1'b1, 2'b01, 2'b00);
    tick();
    checkOutput("tieIdle", 2'b00, 1'b0, 1'b1, 2'b00, 2'b00);
    tick();
    checkOutput("tieLoad1", 2'b10, 1'b0, 1'b0, 2'b00, 2'b00);
    checkVal("tieMin1", int'(bus.min), 1);
    checkVal("tieMax1", int'(bus.max), 5);
    tick();
    checkOutput("tieRun1", 2'b10, 1'b1, 1'b1, 2'b00, 2'b00);
    bus.req = 2'b00;
    tick();
    checkOutput("tieDrop", 2'b00, 1'b0, 1'b1, 2'b00, 2'b00);

    // request withdrawn after the first bounce aborts silently
    setBounds(3, 10, 3, 1, 5, 1);
    applyStimulus(2'b01, 1'b0);
    tick();
    checkOutput("dropLoad", 2'b01, 1'b0, 1'b0, 2'b00, 2'b00);
    tick();
    checkOutput("dropRun", 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
    checkVal("dropMin", int'(bus.min), 3);
    checkVal("dropMax", int'(bus.max), 10);
    bus.direction = 1'b1;
    tick();
    checkOutput("dropBounce1", 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
    bus.req = 2'b00;
    tick();
    checkOutput("dropIdle", 2'b00, 1'b0, 1'b1, 2'b00, 2'b00);
    tick();
    checkOutput("dropNoDone", 2'b00, 1'b0, 1'b1, 2'b00, 2'b00);

    // asynchronous reset in the middle of RUN
    setBounds(0, 4, 2, 1, 5, 1);
    bus.req = 2'b01;
    tick();
    tick();
    checkOutput("midRun", 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReset", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    checkVal("asyncMin", int'(bus.min), 0);
    checkVal("asyncMax", int'(bus.max), 0);
    bus.direction = 1'b0;
    tick();
    bus.req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("relBeforeEdge", 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("relIdle%0d", i), 2'b00, 1'b0, 1'b1, 2'b00, 2'b00);
    end

`ifdef PPS_FLIP_EN
    setBounds(0, 4, 1, 1, 5, 1);
    bus.req = 2'b01;
    tick();
    tick();
    checkOutput("flipRun", 2'b01, 1'b1, 1'b1, 2'b00, 2'b00);
    bus.flip_req = 2'b01;
    tick();
    checkOutput("flipDone", 2'b01, 1'b0, 1'b1, 2'b01, 2'b00);
    checkVal("flipPulse", int'(bus.flip), 1);
    tick();
    checkVal("flipPulseEnd", int'(bus.flip), 0);
    bus.flip_req = 2'b00;
    bus.req      = 2'b00;
    tick();
`endif

    // random traffic against the reference model
    setBounds(2, 9, 2, 1, 12, 1);
    doReset(2'b00);
    modelReset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) bus.req[0] = ~bus.req[0];
      if ($urandom_range(0, 7) == 0) bus.req[1] = ~bus.req[1];
      if ($urandom_range(0, 2) == 0) bus.direction = ~bus.direction;
      if ($urandom_range(0, 15) == 0)
        setBounds($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                  $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
      @(posedge clk);
      modelStep();
      #1;
      checkOutput($sformatf("rand%0d", c), eGnt, eEn, eCrn, eDone, eErr);
      if (mBusy) begin
        checkVal($sformatf("rand%0dMin", c), int'(bus.min), mMin);
        checkVal($sformatf("rand%0dMax", c), int'(bus.max), mMax);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
